mem_wb_pipe_reg: RTL and testbench
==================================

# mem_wb_pipe_reg

Parametrised MEM/WB pipeline register with a ready/valid handshake, a 2-entry skid buffer, flush and bubble tracking. It sits between the memory stage and the register-file write-back port. It replaces the free-running stage register: the pipeline can now stall without losing data, squash in-flight results, and never issue a register write from a bubble.

## Interface
- DATA_W, 32, width of memory-result and ALU-result fields
- REG_W, 5, width of destination-register index
- CNT_W, 16, width of bubble counter (saturating)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; equals !skid_valid (registered state, no combinational path from out_ready)
- regwrite_in  in  1  register-write enable of entry
- memtoreg_in  in  1  write-back source select of entry
- memres_in  in  DATA_W  memory read data
- alures_in  in  DATA_W  ALU result
- writeregister_in  in  REG_W  destination register index
- flush  in  1  squash all held entries
- out_valid  out  1  main slot holds a valid entry
- out_ready  in  1  write-back consumes entry
- regwrite_out  out  1  main-slot regwrite AND out_valid
- memtoreg_out  out  1  main-slot memtoreg
- memres_out  out  DATA_W  main-slot memory data
- alures_out  out  DATA_W  main-slot ALU result
- writeregister_out  out  REG_W  main-slot destination
- wb_data_out  out  DATA_W  memtoreg_out ? memres_out : alures_out (combinational from registers)
- bubble_count  out  CNT_W  cycles with out_valid=0 since reset, saturates at all-ones

## Operation
- Storage: main slot (drives outputs) and skid slot, each with a valid bit. Invariant: skid_valid implies main_valid.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- Per-edge update, priority order:
  - flush=1: main_valid<=0, skid_valid<=0; any push that cycle is discarded; data fields retain their values.
  - main empty, push: entry -> main.
  - main full, pop, skid empty, push: entry -> main (direct replace, skid stays empty).
  - main full, pop, skid empty, no push: main_valid<=0.
  - main full, pop, skid full: skid -> main, skid_valid<=0 (in_ready was 0, so no push).
  - main full, no pop, push: entry -> skid.
  - main full, no pop, no push: hold.
- regwrite_out is forced to 0 whenever out_valid=0, so a bubble or flushed entry never writes the register file.
- bubble_count increments on each edge where out_valid=0 and count is not all-ones. flush does not clear it.

## Timing
- Reset (async assert, released synchronously to clk by the system): main_valid=0, skid_valid=0, all data/control fields=0, bubble_count=0. Therefore out_valid=0, regwrite_out=0, wb_data_out=0 and in_ready=1.
- Latency: an entry pushed at edge N is presented with out_valid=1 after edge N.
- Throughput: one entry per cycle while out_ready=1.
- out_ready may drop at any cycle. Up to one extra entry is absorbed in skid. in_ready deasserts the cycle after the skid fills and reasserts the cycle after the skid drains.
- Output data and the control fields other than regwrite_out are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards both slots immediately, regardless of clk.

## Test plan
- Reset: drive rst_n=0 between edges with both slots full -> out_valid, regwrite_out, bubble_count and all data drop to 0 immediately; in_ready=1.
- Streaming: out_ready=1, push A (alures=0x11, wr=3, regwrite=1, memtoreg=0), then B (memres=0x22, memtoreg=1) on consecutive cycles -> A appears one cycle after its push with wb_data_out=0x11, B the next cycle with wb_data_out=0x22; in_ready stays 1.
- Stall/skid: out_ready=0, push A, B, C -> A held in main, B in skid, in_ready=0, C not accepted. Release out_ready -> A, then B in order; in_ready=1 after the skid drains.
- Flush: both slots full, assert flush together with in_valid=1 -> next cycle out_valid=0, regwrite_out=0, in_ready=1; the pushed entry is never output.
- Simultaneous pop+push with main full and skid empty -> new entry replaces main in one cycle, skid stays empty.
- Bubble counter: CNT_W=4, hold in_valid=0 for 20 cycles -> bubble_count saturates at 15.

Source files
------------

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM/WB stage handshake bundle: upstream entry, flush, and write-back side.
// The master drives entries and out_ready; the slave is the pipeline register.
interface mem_wb_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              regwrite_in;
    logic              memtoreg_in;
    logic [DATA_W-1:0] memres_in;
    logic [DATA_W-1:0] alures_in;
    logic [REG_W-1:0]  writeregister_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              regwrite_out;
    logic              memtoreg_out;
    logic [DATA_W-1:0] memres_out;
    logic [DATA_W-1:0] alures_out;
    logic [REG_W-1:0]  writeregister_out;
    logic [DATA_W-1:0] wb_data_out;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output in_valid, regwrite_in, memtoreg_in,
        output memres_in, alures_in, writeregister_in,
        output flush, out_ready,
        input  in_ready, out_valid, regwrite_out, memtoreg_out,
        input  memres_out, alures_out, writeregister_out,
        input  wb_data_out, bubble_count
    );

    modport slave (
        input  in_valid, regwrite_in, memtoreg_in,
        input  memres_in, alures_in, writeregister_in,
        input  flush, out_ready,
        output in_ready, out_valid, regwrite_out, memtoreg_out,
        output memres_out, alures_out, writeregister_out,
        output wb_data_out, bubble_count
    );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: main slot + skid slot with ready/valid handshake,
// flush squashing and a saturating count of bubble cycles.
module mem_wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_wb_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic              rw;
        logic              mtr;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  wr;
    } entry_t;

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_e;
    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0] bub_q, bub_d;
    logic             push;
    logic             pop;

    always_comb begin
        in_e.rw  = bus.regwrite_in;
        in_e.mtr = bus.memtoreg_in;
        in_e.mem = bus.memres_in;
        in_e.alu = bus.alures_in;
        in_e.wr  = bus.writeregister_in;
    end

    assign push = bus.in_valid && !skid_vld_q;
    assign pop  = main_vld_q && bus.out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (push) begin
                main_d     = in_e;
                main_vld_d = 1'b1;
            end
        end else if (pop) begin
            // skid can only be full when in_ready was low, so no push here
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (push) begin
                main_d = in_e;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (push) begin
            skid_d     = in_e;
            skid_vld_d = 1'b1;
        end
    end

    always_comb begin
        bub_d = bub_q;
        if (!main_vld_q && (bub_q != {CNT_W{1'b1}})) begin
            bub_d = bub_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            bub_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            bub_q      <= bub_d;
        end
    end

    assign bus.in_ready          = !skid_vld_q;
    assign bus.out_valid         = main_vld_q;
    assign bus.regwrite_out      = main_q.rw && main_vld_q;
    assign bus.memtoreg_out      = main_q.mtr;
    assign bus.memres_out        = main_q.mem;
    assign bus.alures_out        = main_q.alu;
    assign bus.writeregister_out = main_q.wr;
    assign bus.wb_data_out       = main_q.mtr ? main_q.mem : main_q.alu;
    assign bus.bubble_count      = bub_q;
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: directed entries, queue-based
// monitor on write-back pops, plus a CNT_W=4 instance for saturation.
module tb_mem_wb_pipe_reg;
    typedef struct {
        logic [31:0] wb;
        logic [4:0]  wr;
        logic        rw;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    mem_wb_pipe_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();
    mem_wb_pipe_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  sbus ();

    mem_wb_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mem_wb_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(4)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] wr);
        bus.in_valid         = v;
        bus.regwrite_in      = rw;
        bus.memtoreg_in      = mtr;
        bus.memres_in        = mem;
        bus.alures_in        = alu;
        bus.writeregister_in = wr;
    endtask

    task automatic expect_entry(input logic [31:0] wb, input logic [4:0] wr,
                                input logic rw);
        exp_t e;
        e.wb = wb;
        e.wr = wr;
        e.rw = rw;
        sb.push_back(e);
    endtask

    // Monitor: every accepted write-back must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got wb=%0h expected none",
                         bus.wb_data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_wb", {32'd0, bus.wb_data_out}, {32'd0, e.wb});
                chk("mon_wr", {59'd0, bus.writeregister_out}, {59'd0, e.wr});
                chk("mon_rw", {63'd0, bus.regwrite_out}, {63'd0, e.rw});
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        sbus.in_valid         = 1'b0;
        sbus.regwrite_in      = 1'b0;
        sbus.memtoreg_in      = 1'b0;
        sbus.memres_in        = 32'd0;
        sbus.alures_in        = 32'd0;
        sbus.writeregister_in = 5'd0;
        sbus.flush            = 1'b0;
        sbus.out_ready        = 1'b1;
        #3;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_regwrite", {63'd0, bus.regwrite_out}, 64'd0);
        chk("rst_wb_data", {32'd0, bus.wb_data_out}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_bubble", {48'd0, bus.bubble_count}, 64'd0);
        #10;
        rst_n = 1'b1;

        // streaming
        step();
        #1;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h11, 5'd3);
        expect_entry(32'h11, 5'd3, 1'b1);
        step();
        chk("str_a_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("str_a_wb", {32'd0, bus.wb_data_out}, 64'h11);
        chk("str_a_ready", {63'd0, bus.in_ready}, 64'd1);
        #1;
        drive(1'b1, 1'b1, 1'b1, 32'h22, 32'h99, 5'd4);
        expect_entry(32'h22, 5'd4, 1'b1);
        step();
        chk("str_b_wb", {32'd0, bus.wb_data_out}, 64'h22);
        chk("str_b_ready", {63'd0, bus.in_ready}, 64'd1);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        chk("str_drain", {63'd0, bus.out_valid}, 64'd0);
        chk("str_drain_rw", {63'd0, bus.regwrite_out}, 64'd0);

        // stall and skid
        #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h33, 5'd5);
        expect_entry(32'h33, 5'd5, 1'b1);
        step();
        chk("stl_a_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stl_a_ready", {63'd0, bus.in_ready}, 64'd1);
        #1;
        drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 5'd6);
        expect_entry(32'h44, 5'd6, 1'b0);
        step();
        chk("stl_full_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("stl_hold_wb", {32'd0, bus.wb_data_out}, 64'h33);
        #1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd7);
        step();
        chk("stl_c_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("stl_c_wb", {32'd0, bus.wb_data_out}, 64'h33);
        chk("stl_c_alu", {32'd0, bus.alures_out}, 64'h33);
        chk("stl_c_wr", {59'd0, bus.writeregister_out}, 64'd5);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.out_ready = 1'b1;
        step();
        chk("stl_b_wb", {32'd0, bus.wb_data_out}, 64'h44);
        chk("stl_b_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("stl_b_rw", {63'd0, bus.regwrite_out}, 64'd0);
        step();
        chk("stl_empty", {63'd0, bus.out_valid}, 64'd0);

        // flush with both slots full and a concurrent push
        #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h66, 5'd8);
        step();
        #1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h67, 5'd9);
        step();
        chk("fl_full", {63'd0, bus.in_ready}, 64'd0);
        #1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h68, 5'd10);
        bus.flush = 1'b1;
        step();
        chk("fl_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("fl_rw", {63'd0, bus.regwrite_out}, 64'd0);
        chk("fl_ready", {63'd0, bus.in_ready}, 64'd1);
        #1;
        bus.flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("fl_no_ghost", {63'd0, bus.out_valid}, 64'd0);

        // pop and push together with skid empty: direct replace
        #1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd11);
        expect_entry(32'h77, 5'd11, 1'b1);
        step();
        chk("rep_g_wb", {32'd0, bus.wb_data_out}, 64'h77);
        #1;
        drive(1'b1, 1'b1, 1'b1, 32'h88, 32'h1, 5'd12);
        expect_entry(32'h88, 5'd12, 1'b1);
        step();
        chk("rep_h_wb", {32'd0, bus.wb_data_out}, 64'h88);
        chk("rep_h_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rep_h_valid", {63'd0, bus.out_valid}, 64'd1);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        chk("rep_empty", {63'd0, bus.out_valid}, 64'd0);

        // asynchronous reset with both slots full
        #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hAA, 5'd13);
        step();
        #1;
        drive(1'b1, 1'b1, 1'b1, 32'hBB, 32'h0, 5'd14);
        step();
        chk("ar_pre_full", {63'd0, bus.in_ready}, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("ar_rw", {63'd0, bus.regwrite_out}, 64'd0);
        chk("ar_wb", {32'd0, bus.wb_data_out}, 64'd0);
        chk("ar_wr", {59'd0, bus.writeregister_out}, 64'd0);
        chk("ar_bubble", {48'd0, bus.bubble_count}, 64'd0);
        chk("ar_ready", {63'd0, bus.in_ready}, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.out_ready = 1'b1;
        #2;
        rst_n = 1'b1;

        // idle: both counters run, the 4-bit one saturates
        for (int i = 0; i < 14; i++) step();
        chk("bub_main_14", {48'd0, bus.bubble_count}, 64'd14);
        chk("bub_small_14", {60'd0, sbus.bubble_count}, 64'd14);
        for (int i = 0; i < 6; i++) step();
        chk("bub_main_20", {48'd0, bus.bubble_count}, 64'd20);
        chk("bub_small_sat", {60'd0, sbus.bubble_count}, 64'd15);

        step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
